// File: rtl/aclk_load_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// aclk_pkg
// Shared types for the alarm-clock load sequencer:
//   aclk_state_t  - sequencer FSM state encoding
//   ACLK_*        - rsp_err completion codes
//   hhmm_t        - packed HH:MM BCD payload {h1,h0,m1,m0}
//   hhmm_legal()  - range check of a BCD time of day (00:00 .. 23:59)
// ---------------------------------------------------------------------------
package aclk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_LOAD   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_VERIFY = 3'd5,
        ST_RESP   = 3'd6
    } aclk_state_t;

    localparam logic [1:0] ACLK_OK        = 2'b00;
    localparam logic [1:0] ACLK_BAD_DIGIT = 2'b01;
    localparam logic [1:0] ACLK_VERIFY_TO = 2'b10;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    function automatic logic hhmm_legal(hhmm_t t);
        return (t.h1 <= 2'd2) && (t.h0 <= 4'd9) && (t.m1 <= 4'd5) &&
               (t.m0 <= 4'd9) && ((t.h1 != 2'd2) || (t.h0 <= 4'd3));
    endfunction

endpackage

// File: rtl/aclk_load_sequencer_if.sv
// ---------------------------------------------------------------------------
// aclk_load_sequencer_if
// Requester-side bus of the load sequencer (two requesters, fields packed
// {r1,r0}).
//   req_valid/req_ready : request handshake. A requester raises req_valid[i]
//     with a stable payload (req_alarm/req_h1/req_h0/req_m1/req_m0 slice i)
//     and keeps both stable until it sees req_ready[i]; req_ready is a
//     one-cycle, one-hot accept pulse and the payload is captured on that
//     transfer. Dropping valid before ready withdraws the request harmlessly.
//   rsp_valid/rsp_id/rsp_err : one-cycle completion pulse, no back-pressure.
// Modports: master = requesters, slave = sequencer.
// ---------------------------------------------------------------------------
interface aclk_load_sequencer_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req_alarm;
    logic [3:0] req_h1;
    logic [7:0] req_h0;
    logic [7:0] req_m1;
    logic [7:0] req_m0;
    logic       rsp_valid;
    logic       rsp_id;
    logic [1:0] rsp_err;

    modport master (
        output req_valid, req_alarm, req_h1, req_h0, req_m1, req_m0,
        input  req_ready, rsp_valid, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_alarm, req_h1, req_h0, req_m1, req_m0,
        output req_ready, rsp_valid, rsp_id, rsp_err
    );
endinterface

// File: rtl/aclk_load_sequencer_arb.sv
// ---------------------------------------------------------------------------
// aclk_rr_arb2
// Two-way round-robin arbiter. The pointer's requester wins if valid,
// otherwise the other one. On advance with a live request the pointer moves
// to the requester that was not granted.
// Ports: clk, reset_n (sync, active-low), req[1:0], advance,
//        gnt[1:0] (one-hot, combinational), gnt_id.
// ---------------------------------------------------------------------------
module aclk_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       gnt_id
);
    logic ptr;

    always_comb begin
        gnt    = 2'b00;
        gnt_id = ptr;
        if (req[ptr]) begin
            gnt[ptr] = 1'b1;
            gnt_id   = ptr;
        end else if (req[~ptr]) begin
            gnt[~ptr] = 1'b1;
            gnt_id    = ~ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (advance && (|req)) begin
            ptr <= ~gnt_id;
        end
    end
endmodule

// File: rtl/aclk_load_sequencer.sv
// ---------------------------------------------------------------------------
// aclk_load_sequencer
// Arbitrates LD_time/LD_alarm writes from two requesters into the alarm-clock
// core, range-checks the BCD payload, frames the digit bus with setup/hold
// around the LD strobe and, for time loads, waits for the core readback.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   rif (slave)                   requester handshake + completion response
//   H_in1/H_in0/M_in1/M_in0       digit bus to core
//   LD_time/LD_alarm              load strobes to core
//   H_out1/H_out0/M_out1/M_out0   core time readback
//   state_dbg                     current FSM state
// All core/response outputs are registered decodes of the current state, so
// they trail the state by one cycle; that lag is what makes the LD strobe
// rise 2+SETUP_CYC cycles after the ready pulse.
// ---------------------------------------------------------------------------
module aclk_load_sequencer
    import aclk_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned LD_CYC    = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned VERIFY_TO = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    aclk_load_sequencer_if.slave   rif,
    output logic [1:0]             H_in1,
    output logic [3:0]             H_in0,
    output logic [3:0]             M_in1,
    output logic [3:0]             M_in0,
    output logic                   LD_time,
    output logic                   LD_alarm,
    input  logic [1:0]             H_out1,
    input  logic [3:0]             H_out0,
    input  logic [3:0]             M_out1,
    input  logic [3:0]             M_out0,
    output aclk_state_t            state_dbg
);
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] LD_LAST    = 8'(LD_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = (HOLD_CYC == 0) ? 8'd0 : 8'(HOLD_CYC - 1);
    localparam logic [7:0] VTO_LAST   = 8'(VERIFY_TO - 1);

    aclk_state_t state;
    logic [7:0]  cnt;
    hhmm_t       cap;
    logic        cap_id;
    logic        cap_alarm;
    logic [1:0]  err;

    logic [1:0]  gnt;
    logic        gnt_id;
    hhmm_t       pay;
    hhmm_t       readback;
    logic        pay_alarm;
    logic        drive_digits;

    logic [1:0]  req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [1:0]  rsp_err_q;

    aclk_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (rif.req_valid),
        .advance (state == ST_IDLE),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        pay.h1    = gnt_id ? rif.req_h1[3:2] : rif.req_h1[1:0];
        pay.h0    = gnt_id ? rif.req_h0[7:4] : rif.req_h0[3:0];
        pay.m1    = gnt_id ? rif.req_m1[7:4] : rif.req_m1[3:0];
        pay.m0    = gnt_id ? rif.req_m0[7:4] : rif.req_m0[3:0];
        pay_alarm = rif.req_alarm[gnt_id];
    end

    assign readback     = {H_out1, H_out0, M_out1, M_out0};
    assign drive_digits = (state == ST_SETUP) || (state == ST_LOAD) || (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            cap         <= '0;
            cap_id      <= 1'b0;
            cap_alarm   <= 1'b0;
            err         <= ACLK_OK;
            req_ready_q <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= ACLK_OK;
            {H_in1, H_in0, M_in1, M_in0} <= '0;
            LD_time     <= 1'b0;
            LD_alarm    <= 1'b0;
        end else begin
            req_ready_q <= (state == ST_IDLE) ? gnt : 2'b00;
            rsp_valid_q <= (state == ST_RESP);
            rsp_id_q    <= (state == ST_RESP) ? cap_id : 1'b0;
            rsp_err_q   <= (state == ST_RESP) ? err : ACLK_OK;
            {H_in1, H_in0, M_in1, M_in0} <= drive_digits ? cap : '0;
            LD_time     <= (state == ST_LOAD) && !cap_alarm;
            LD_alarm    <= (state == ST_LOAD) && cap_alarm;

            case (state)
                ST_IDLE: begin
                    cnt <= 8'd0;
                    if (|gnt) begin
                        cap       <= pay;
                        cap_id    <= gnt_id;
                        cap_alarm <= pay_alarm;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    cnt <= 8'd0;
                    if (hhmm_legal(cap)) begin
                        err   <= ACLK_OK;
                        state <= ST_SETUP;
                    end else begin
                        err   <= ACLK_BAD_DIGIT;
                        state <= ST_RESP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= 8'd0;
                        state <= ST_LOAD;
                    end else begin
                        cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    end
                end
                ST_LOAD: begin
                    if (cnt == LD_LAST) begin
                        cnt <= 8'd0;
                        if (HOLD_CYC != 0) state <= ST_HOLD;
                        else               state <= cap_alarm ? ST_RESP : ST_VERIFY;
                    end else begin
                        cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= 8'd0;
                        state <= cap_alarm ? ST_RESP : ST_VERIFY;
                    end else begin
                        cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    end
                end
                ST_VERIFY: begin
                    // Every VERIFY cycle compares, including the last one before timeout.
                    if (readback == cap) begin
                        err   <= ACLK_OK;
                        state <= ST_RESP;
                    end else if (cnt == VTO_LAST) begin
                        err   <= ACLK_VERIFY_TO;
                        state <= ST_RESP;
                    end else begin
                        cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    cnt   <= 8'd0;
                    state <= ST_IDLE;
                end
                default: begin
                    cnt   <= 8'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rif.req_ready = req_ready_q;
    assign rif.rsp_valid = rsp_valid_q;
    assign rif.rsp_id    = rsp_id_q;
    assign rif.rsp_err   = rsp_err_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_aclk_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aclk_load_sequencer
// Self-checking bench for aclk_load_sequencer: a directed table of
// transactions, randomized transactions against a timing-window reference
// model, and hand-written round-robin and mid-LOAD reset sequences.
// A small core model loads the digit bus on LD_time and drives the readback;
// with track=0 the readback is held at 00:00.
// ---------------------------------------------------------------------------
module tb_aclk_load_sequencer;
    import aclk_pkg::*;

    localparam int S = 1;
    localparam int L = 2;
    localparam int H = 1;
    localparam int T = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    aclk_load_sequencer_if rif ();

    logic [1:0]  H_in1;
    logic [3:0]  H_in0, M_in1, M_in0;
    logic        LD_time, LD_alarm;
    logic [1:0]  H_out1;
    logic [3:0]  H_out0, M_out1, M_out0;
    aclk_state_t state_dbg;

    aclk_load_sequencer #(.SETUP_CYC(S), .LD_CYC(L), .HOLD_CYC(H), .VERIFY_TO(T)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rif       (rif),
        .H_in1     (H_in1),
        .H_in0     (H_in0),
        .M_in1     (M_in1),
        .M_in0     (M_in0),
        .LD_time   (LD_time),
        .LD_alarm  (LD_alarm),
        .H_out1    (H_out1),
        .H_out0    (H_out0),
        .M_out1    (M_out1),
        .M_out0    (M_out0),
        .state_dbg (state_dbg)
    );

    // ---------------- core model ----------------
    logic [13:0] core_q = '0;
    bit          track  = 1'b1;
    always @(posedge clk) if (LD_time) core_q <= {H_in1, H_in0, M_in1, M_in0};
    assign {H_out1, H_out0, M_out1, M_out0} = track ? core_q : 14'd0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: time-of-day legality with plain arithmetic.
    function automatic logic [1:0] model_err(input bit alarm, input hhmm_t v, input bit trk);
        int hours, mins;
        hours = int'(v.h1) * 10 + int'(v.h0);
        mins  = int'(v.m1) * 10 + int'(v.m0);
        if (v.h0 > 9 || v.m0 > 9 || hours >= 24 || mins >= 60) return ACLK_BAD_DIGIT;
        if (alarm) return ACLK_OK;
        if (trk || v == 14'd0) return ACLK_OK;
        return ACLK_VERIFY_TO;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        rif.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk($sformatf("%s outputs zero", tag),
            {10'd0, rif.req_ready, rif.rsp_valid, rif.rsp_id, rif.rsp_err,
             H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm}, 32'd0);
        chk($sformatf("%s state idle", tag), state_dbg, ST_IDLE);
        reset_n = 1'b1;
    endtask

    task automatic set_payload(input bit id, input bit alarm, input hhmm_t v);
        rif.req_alarm[id]       = alarm;
        rif.req_h1[id*2 +: 2]   = v.h1;
        rif.req_h0[id*4 +: 4]   = v.h0;
        rif.req_m1[id*4 +: 4]   = v.m1;
        rif.req_m0[id*4 +: 4]   = v.m0;
    endtask

    // One full transaction; offsets are cycles after the ready pulse.
    task automatic run_txn(input bit id, input bit alarm, input hhmm_t v, input bit trk,
                           input logic [1:0] exp_err, input string tag);
        int r_cyc, off, rsp_off, exp_rsp_off, dig_bad, ld_t_bad, ld_a_bad;
        bit got, legal, in_ld, in_dig;
        logic [13:0] dig, exp_dig;
        logic        rid;
        logic [1:0]  rerr;
        dig_bad = 0; ld_t_bad = 0; ld_a_bad = 0; rsp_off = -1; rid = 1'b0; rerr = 2'b00;
        legal = (exp_err != ACLK_BAD_DIGIT);

        @(negedge clk);
        track = trk;
        set_payload(id, alarm, v);
        rif.req_valid[id] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rif.req_ready != 2'b00) begin got = 1'b1; break; end
        end
        rif.req_valid[id] = 1'b0;
        if (!got) begin
            chk($sformatf("%s ready seen", tag), 0, 1);
            return;
        end
        chk($sformatf("%s ready one-hot", tag), rif.req_ready, 2'b01 << id);
        r_cyc = cyc;

        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            off     = cyc - r_cyc;
            in_dig  = legal && off >= 2 && off < 2 + S + L + H;
            in_ld   = legal && off >= 2 + S && off < 2 + S + L;
            exp_dig = in_dig ? v : 14'd0;
            dig     = {H_in1, H_in0, M_in1, M_in0};
            if (dig !== exp_dig) dig_bad++;
            if (LD_time  !== (in_ld && !alarm)) ld_t_bad++;
            if (LD_alarm !== (in_ld && alarm))  ld_a_bad++;
            if (rif.rsp_valid) begin
                rsp_off = off; rid = rif.rsp_id; rerr = rif.rsp_err;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk($sformatf("%s rsp seen", tag), 0, 1);
            return;
        end
        if (!legal)                        exp_rsp_off = 2;
        else if (alarm)                    exp_rsp_off = 2 + S + L + H;
        else if (exp_err == ACLK_OK)       exp_rsp_off = 3 + S + L + H;
        else                               exp_rsp_off = 2 + S + L + H + T;
        chk($sformatf("%s digit window errs", tag), dig_bad, 0);
        chk($sformatf("%s LD_time window errs", tag), ld_t_bad, 0);
        chk($sformatf("%s LD_alarm window errs", tag), ld_a_bad, 0);
        chk($sformatf("%s rsp latency", tag), rsp_off, exp_rsp_off);
        chk($sformatf("%s rsp_id", tag), rid, id);
        chk($sformatf("%s rsp_err", tag), rerr, exp_err);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         id;
        bit         alarm;
        hhmm_t      v;
        bit         trk;
        logic [1:0] err;
    } vec_t;

    vec_t tbl[8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int ready_seen, rsp_seen, last_rsp, ok;
        hhmm_t rv;
        rif.req_valid = 2'b00;
        rif.req_alarm = 2'b00;
        rif.req_h1 = '0; rif.req_h0 = '0; rif.req_m1 = '0; rif.req_m0 = '0;

        tbl[0] = '{1'b0, 1'b0, hhmm_t'{2'd1, 4'd2, 4'd3, 4'd4}, 1'b1, ACLK_OK};
        tbl[1] = '{1'b1, 1'b1, hhmm_t'{2'd2, 4'd3, 4'd5, 4'd9}, 1'b1, ACLK_OK};
        tbl[2] = '{1'b0, 1'b0, hhmm_t'{2'd2, 4'd4, 4'd0, 4'd0}, 1'b1, ACLK_BAD_DIGIT};
        tbl[3] = '{1'b1, 1'b0, hhmm_t'{2'd1, 4'd3, 4'd6, 4'd0}, 1'b1, ACLK_BAD_DIGIT};
        tbl[4] = '{1'b0, 1'b1, hhmm_t'{2'd3, 4'd0, 4'd0, 4'd0}, 1'b1, ACLK_BAD_DIGIT};
        tbl[5] = '{1'b1, 1'b0, hhmm_t'{2'd0, 4'd7, 4'd4, 4'd5}, 1'b0, ACLK_VERIFY_TO};
        tbl[6] = '{1'b0, 1'b0, hhmm_t'{2'd0, 4'd9, 4'd5, 4'd9}, 1'b1, ACLK_OK};
        tbl[7] = '{1'b1, 1'b0, hhmm_t'{2'd0, 4'd0, 4'd0, 4'd0}, 1'b0, ACLK_OK};

        apply_reset("reset");

        for (int k = 0; k < 8; k++)
            run_txn(tbl[k].id, tbl[k].alarm, tbl[k].v, tbl[k].trk, tbl[k].err,
                    $sformatf("tbl%0d", k));

        // ---------------- randomized transactions ----------------
        for (int k = 0; k < 20; k++) begin
            bit rid_b, ral, rtrk;
            rid_b = 1'($urandom_range(0, 1));
            ral   = 1'($urandom_range(0, 1));
            rtrk  = ($urandom_range(0, 3) != 0);
            rv.h1 = 2'($urandom_range(0, 3));
            rv.h0 = 4'($urandom_range(0, 11));
            rv.m1 = 4'($urandom_range(0, 7));
            rv.m0 = 4'($urandom_range(0, 11));
            run_txn(rid_b, ral, rv, rtrk, model_err(ral, rv, rtrk), $sformatf("rnd%0d", k));
        end

        // ---------------- round-robin with both requesters always valid ----------------
        apply_reset("rr reset");
        track = 1'b1;
        set_payload(1'b0, 1'b1, hhmm_t'{2'd0, 4'd1, 4'd0, 4'd0});
        set_payload(1'b1, 1'b1, hhmm_t'{2'd0, 4'd2, 4'd0, 4'd0});
        @(negedge clk);
        rif.req_valid = 2'b11;
        last_rsp = cyc;
        for (int k = 0; k < 4; k++) begin
            ok = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (rif.req_ready != 2'b00) begin ok = 1; break; end
            end
            if (k == 3) rif.req_valid = 2'b00;
            if (ok == 0) begin
                chk($sformatf("rr%0d ready seen", k), 0, 1);
                break;
            end
            chk($sformatf("rr%0d grant", k), rif.req_ready, 2'b01 << (k % 2));
            chk($sformatf("rr%0d ready after prev rsp", k), (cyc > last_rsp), 1);
            ok = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (rif.rsp_valid) begin ok = 1; break; end
            end
            chk($sformatf("rr%0d rsp seen", k), ok, 1);
            chk($sformatf("rr%0d rsp_id", k), rif.rsp_id, k % 2);
            last_rsp = cyc;
        end
        rif.req_valid = 2'b00;

        // ---------------- reset during LOAD ----------------
        @(negedge clk);
        track = 1'b1;
        set_payload(1'b0, 1'b0, hhmm_t'{2'd1, 4'd0, 4'd1, 4'd0});
        rif.req_valid[0] = 1'b1;
        ready_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rif.req_ready[0]) begin ready_seen = 1; break; end
        end
        rif.req_valid[0] = 1'b0;
        chk("mid-reset ready seen", ready_seen, 1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (LD_time) begin ok = 1; break; end
        end
        chk("mid-reset LD_time reached", ok, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid-reset outputs zero",
            {10'd0, rif.req_ready, rif.rsp_valid, rif.rsp_id, rif.rsp_err,
             H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm}, 32'd0);
        reset_n = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rif.rsp_valid) rsp_seen++;
        end
        chk("mid-reset no rsp", rsp_seen, 0);
        run_txn(1'b1, 1'b0, hhmm_t'{2'd2, 4'd0, 4'd4, 4'd5}, 1'b1, ACLK_OK, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
